// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-issue and response signal bundle for alu_cmd_sequencer.
// Optional statistics ports exist only when ALU_SEQ_STATS_EN is defined.
interface alu_cmd_sequencer_if #(
  parameter int DATA_W = 2,
  parameter int SEL_W  = 2,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [SEL_W-1:0]  cmd_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [SEL_W-1:0]  alu_s;
  logic              alu_enable;
  logic [DATA_W-1:0] alu_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [SEL_W-1:0]  rsp_op;
  logic [CNT_W-1:0]  count;
`ifdef ALU_SEQ_STATS_EN
  logic [7:0]        done_count;
  logic              overflow_seen;
`endif

  modport slave (
`ifdef ALU_SEQ_STATS_EN
    output done_count,
    output overflow_seen,
`endif
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_s, alu_enable,
    output rsp_valid, rsp_data, rsp_op, count
  );

  modport master (
`ifdef ALU_SEQ_STATS_EN
    input  done_count,
    input  overflow_seen,
`endif
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_s, alu_enable,
    input  rsp_valid, rsp_data, rsp_op, count
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands in a FIFO, issues them one at a time to arithmetic_unit
// and holds each result for a valid/ready response. Optional stats: ALU_SEQ_STATS_EN.
module alu_cmd_sequencer #(
  parameter int DATA_W = 2,
  parameter int SEL_W  = 2,
  parameter int DEPTH  = 4
) (
  input logic               clk,
  input logic               rst,
  alu_cmd_sequencer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [DATA_W-1:0] r_mem_a  [DEPTH];
  logic [DATA_W-1:0] r_mem_b  [DEPTH];
  logic [SEL_W-1:0]  r_mem_op [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [SEL_W-1:0]  r_alu_s;
  logic              r_alu_enable;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic [SEL_W-1:0]  r_rsp_op;

  logic w_cmd_ready;
  logic w_not_empty;
  logic w_push;
  logic w_pop;

  // The FIFO head is consumed only when the FSM loads it into the ALU registers.
  assign w_cmd_ready = (r_count < DEPTH_C);
  assign w_not_empty = (r_count != {CNT_W{1'b0}});
  assign w_push      = bus.cmd_valid && w_cmd_ready;
  assign w_pop       = w_not_empty &&
                       ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && bus.rsp_ready));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr]  <= bus.cmd_a;
      r_mem_b[r_wr_ptr]  <= bus.cmd_b;
      r_mem_op[r_wr_ptr] <= bus.cmd_op;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_alu_a      <= {DATA_W{1'b0}};
      r_alu_b      <= {DATA_W{1'b0}};
      r_alu_s      <= {SEL_W{1'b0}};
      r_alu_enable <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= {DATA_W{1'b0}};
      r_rsp_op     <= {SEL_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_alu_enable <= 1'b0;
          if (w_pop) begin
            r_alu_a      <= r_mem_a[r_rd_ptr];
            r_alu_b      <= r_mem_b[r_rd_ptr];
            r_alu_s      <= r_mem_op[r_rd_ptr];
            r_alu_enable <= 1'b1;
            r_state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_rsp_data   <= bus.alu_result;
          r_rsp_op     <= r_alu_s;
          r_rsp_valid  <= 1'b1;
          r_alu_enable <= 1'b0;
          r_state      <= ST_HOLD;
        end
        ST_HOLD: begin
          // Releasing a response and issuing the next command share one edge.
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (w_pop) begin
              r_alu_a      <= r_mem_a[r_rd_ptr];
              r_alu_b      <= r_mem_b[r_rd_ptr];
              r_alu_s      <= r_mem_op[r_rd_ptr];
              r_alu_enable <= 1'b1;
              r_state      <= ST_ISSUE;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_alu_enable <= 1'b0;
          r_rsp_valid  <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  logic [7:0] r_done_count;
  logic       r_overflow_seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_done_count    <= 8'd0;
      r_overflow_seen <= 1'b0;
    end else begin
      if (r_rsp_valid && bus.rsp_ready) r_done_count <= r_done_count + 8'd1;
      if (bus.cmd_valid && !w_cmd_ready) r_overflow_seen <= 1'b1;
    end
  end

  assign bus.done_count    = r_done_count;
  assign bus.overflow_seen = r_overflow_seen;
`endif

  assign bus.cmd_ready  = w_cmd_ready;
  assign bus.count      = r_count;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_s      = r_alu_s;
  assign bus.alu_enable = r_alu_enable;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_op     = r_rsp_op;
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream issue stage for arithmetic_unit. Accepts operation commands (a, b, op select) over a valid/ready interface and buffers them in a small FIFO. Issues one command at a time to arithmetic_unit by driving a/b/s/enable. Captures the returned result and presents it downstream over a valid/ready response interface.

Parameters:
DATA_W, 2, operand and result width; matches arithmetic_unit a/b/result.
SEL_W, 2, op select width; matches arithmetic_unit s.
DEPTH, 4, command FIFO entries; must be a power of 2, minimum 2.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  reset; synchronous, active-high.
cmd_valid  input  1  command present.
cmd_ready  output  1  FIFO can accept; equals (count < DEPTH).
cmd_a  input  DATA_W  operand a.
cmd_b  input  DATA_W  operand b.
cmd_op  input  SEL_W  op select (00 add, 01 sub, 10 mul, 11 AND).
alu_a  output  DATA_W  to arithmetic_unit a; registered.
alu_b  output  DATA_W  to arithmetic_unit b; registered.
alu_s  output  SEL_W  to arithmetic_unit s; registered.
alu_enable  output  1  to arithmetic_unit enable; registered.
alu_result  input  DATA_W  from arithmetic_unit result; combinational path.
rsp_valid  output  1  response held.
rsp_ready  input  1  downstream accepts the response.
rsp_data  output  DATA_W  captured result.
rsp_op  output  SEL_W  op that produced rsp_data.
count  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (sync, rst=1 at an edge) sets outputs as follows:
  - alu_a/alu_b/alu_s = 0, alu_enable = 0.
  - rsp_valid = 0, rsp_data = 0, rsp_op = 0.
  - count = 0, FIFO pointers = 0, FSM = IDLE.
  - Any in-flight command and any pending response is dropped.
  - rst has priority over all other events in the same cycle.
- Push: the FIFO writes on cmd_valid && cmd_ready.
  - When full, cmd_ready = 0 and nothing is written; there is no pass-through on a same-cycle pop.
- Pop: the FIFO head is read only by the FSM, as described below.
  - Push and pop on the same edge leave count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, HOLD.
  - IDLE: alu_enable = 0. If count > 0, pop the head into alu_a/alu_b/alu_s, set alu_enable = 1, and go to ISSUE.
  - ISSUE (exactly 1 cycle, alu_enable = 1):
    - Capture alu_result into rsp_data and alu_s into rsp_op.
    - Set rsp_valid = 1 and alu_enable = 0, then go to HOLD.
  - HOLD: rsp_valid = 1; rsp_data and rsp_op are stable until the handshake.
    - On rsp_ready: clear rsp_valid.
    - On the same edge, if count > 0, pop the next command and go to ISSUE (back-to-back); otherwise go to IDLE.
- alu_a/alu_b/alu_s hold their last issued values while alu_enable = 0.
- Latency: a command accepted at edge N into an empty FIFO in IDLE is loaded at edge N+1, and rsp_valid rises at edge N+2.
- Throughput: one response per 2 cycles with rsp_ready tied high.
- Backpressure: with rsp_ready held low, the FIFO continues to accept until full; no ALU issue occurs while in HOLD.
- Ordering: responses are returned strictly in command order.
- No arithmetic is performed in this block; result width is DATA_W, taken as delivered by arithmetic_unit.

Optional Feature:
Macro ALU_SEQ_STATS_EN.
- Defined:
  - Adds output done_count [7:0], reset to 0.
  - Increments on each rsp_valid && rsp_ready; wraps 255 -> 0.
  - Adds output overflow_seen [0:0], set sticky when cmd_valid && !cmd_ready occurs; cleared only by rst.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
All scenarios run with arithmetic_unit connected.
- Single op: push a=10, b=01, op=00 with rsp_ready=1.
  -> alu_enable high for exactly 1 cycle at N+1; rsp_valid at N+2; rsp_data=11, rsp_op=00.
- Four ops back-to-back (op 00, 01, 10, 11; all a=10, b=01) with rsp_ready=1.
  -> rsp_data in order 11, 01, 10, 00; rsp_valid pulses every 2 cycles.
- Backpressure: rsp_ready=0, push 5 commands with DEPTH=4.
  -> First pops into ISSUE/HOLD; 4 more fill the FIFO; cmd_ready drops with count=4.
  -> With the stats macro defined, overflow_seen=1 on a further push attempt.
  -> Releasing rsp_ready drains all 5 responses in order.
- Reset mid-operation: assert rst for 1 cycle while in HOLD with count=2.
  -> Next cycle: rsp_valid=0, count=0, alu_enable=0, cmd_ready=1; no stale response afterwards.
- Simultaneous push/pop with count=1 in HOLD and rsp_ready=1.
  -> count stays 1; next cycle is ISSUE with the older command.
- Stats wrap (macro defined): complete 256 responses.
  -> done_count reads 0 after the 256th handshake; it reads 255 after the 255th.
